mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port 1024x32 unified memory between the instruction-fetch requester (port F) and the load/store requester (port D) of the 5-stage MIPS32 pipeline. It arbitrates, sequences one memory transaction at a time and returns read data to the owning port. It also supports a fetch-flush input so the branch logic can squash an in-flight wrong-path fetch. It sits between the pipeline stages and the memory macro.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
RD_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid (legal 1..4)
MAX_STARVE, 3, max consecutive D grants while F is pending before F is forced (legal 1..15)

Ports:
clk1  in  1  sole clock, rising edge
rst_n  in  1  synchronous active-low reset
f_req  in  1  fetch read request; held with f_addr until f_gnt
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  one-cycle pulse: fetch accepted
f_rvalid  out  1  one-cycle pulse: f_rdata valid
f_rdata  out  DATA_W  fetched instruction
f_flush  in  1  squash the outstanding fetch (taken branch)
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
busy  out  1  high while not IDLE

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs 0 (gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy); starvation counter 0; flush flag 0. Reset mid-transaction abandons it: no rvalid issued.
- All outputs registered.
- States: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE: at an edge with any req, pick winner, latch its fields, go ISSUE. Priority: D over F, except F wins when starve_cnt==MAX_STARVE and f_req=1.
- ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata from latched winner; winner's gnt=1 this same cycle. Store -> next IDLE. Read -> RD_WAIT with latency counter loaded.
- RD_WAIT: count RD_LAT-1 cycles (0 cycles when RD_LAT=1), then sample mem_rdata into rdata on the edge at which it is valid, go RESP.
- RESP (1 cycle): owner's rvalid=1; rdata held until next read response. Next IDLE.
- Latency: read request seen at edge T -> gnt in cycle T+1 -> rvalid in cycle T+1+RD_LAT+1. Store: gnt/mem_en in T+1; IDLE again T+2.
- Starvation counter: increments on each D grant while f_req=1 (saturates at MAX_STARVE); clears on any F grant or when f_req=0 in IDLE.
- Flush: f_flush=1 in any cycle from F's ISSUE through RD_WAIT sets flush flag; in RESP f_rvalid is suppressed (f_rdata still updated); flag clears on leaving RESP. f_flush in IDLE or during D transactions has no effect.
- Requests deasserted before gnt are allowed; arbiter only samples req in IDLE.
- Simultaneous f_req and d_req with no starvation: D granted; F waits.
- No address range check; addresses pass through unmodified.

Optional Feature:
Macro ARB_STATS_EN. When defined: adds outputs stat_f_grants[31:0], stat_d_grants[31:0], stat_f_stall[31:0] (cycles f_req=1 with no f_gnt), stat_flushed[15:0] (suppressed fetch responses); wrapping counters, zeroed on reset. When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single fetch, RD_LAT=2, mem[5]=0x2881000A, f_req/f_addr=5 at edge 0 -> f_gnt cycle 1, mem_en=1 mem_addr=5, f_rvalid cycle 4 with f_rdata=0x2881000A.
- Store d_we=1 d_addr=20 d_wdata=0x55 -> d_gnt and mem_en=1 mem_we=1 addr 20 data 0x55 in cycle 1, busy low cycle 2, no d_rvalid.
- f_req and d_req(load) held continuously, MAX_STARVE=3 -> grant order D,D,D,F,D,D,D,F.
- Fetch in flight, f_flush pulse in RD_WAIT -> f_rvalid stays 0, next fetch returns normally; stat_flushed=1 with ARB_STATS_EN.
- rst_n low during RD_WAIT -> next cycle all outputs 0, state IDLE, no rvalid ever for that request.
- RD_LAT=1 and RD_LAT=4 builds: load d_addr=100 -> d_rvalid exactly 3 and 6 cycles after request edge respectively.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory between fetch (F) and load/store (D) requesters.
// Optional build macro ARB_STATS_EN adds grant/stall/flush statistics counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int MAX_STARVE = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              f_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_f_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_f_stall,
  output logic [15:0]       stat_flushed
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  state_t      state;
  logic        own_f;
  logic        flush_flg;
  logic [3:0]  starve_cnt;
  logic [1:0]  lat_cnt;
  logic        f_win;
  logic        f_drop;

  // D normally wins; F is forced through once D has starved it MAX_STARVE times.
  assign f_win  = f_req && (!d_req || starve_cnt == 4'(MAX_STARVE));
  assign f_drop = flush_flg || f_flush;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      own_f      <= 1'b0;
      flush_flg  <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      f_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (!f_req || f_win)
            starve_cnt <= '0;
          else if (starve_cnt != 4'(MAX_STARVE))
            starve_cnt <= starve_cnt + 4'd1;
          if (f_req || d_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            own_f     <= f_win;
            flush_flg <= 1'b0;
            f_gnt     <= f_win;
            d_gnt     <= !f_win;
            mem_en    <= 1'b1;
            mem_we    <= !f_win && d_we;
            mem_addr  <= f_win ? f_addr : d_addr;
            mem_wdata <= f_win ? '0 : d_wdata;
          end
        end
        ISSUE: begin
          lat_cnt <= 2'(RD_LAT - 1);
          if (own_f && f_flush) flush_flg <= 1'b1;
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (own_f && f_flush) flush_flg <= 1'b1;
          if (lat_cnt == 2'd0) begin
            state <= RESP;
            // A squashed fetch still updates f_rdata; only the valid pulse is dropped.
            if (own_f) begin
              f_rdata  <= mem_rdata;
              f_rvalid <= !f_drop;
            end else begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          flush_flg <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      stat_f_grants <= '0;
      stat_d_grants <= '0;
      stat_f_stall  <= '0;
      stat_flushed  <= '0;
    end else begin
      if (f_gnt) stat_f_grants <= stat_f_grants + 32'd1;
      if (d_gnt) stat_d_grants <= stat_d_grants + 32'd1;
      if (f_req && !f_gnt) stat_f_stall <= stat_f_stall + 32'd1;
      if (state == RD_WAIT && lat_cnt == 2'd0 && own_f && f_drop)
        stat_flushed <= stat_flushed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 10, DW = 32, RD_LAT = 2, MAX_STARVE = 3;

  logic clk1 = 1'b0, rst_n = 1'b0;
  logic f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [31:0] stat_f_grants, stat_d_grants, stat_f_stall;
  logic [15:0] stat_flushed;
`endif

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .f_flush(f_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_f_grants(stat_f_grants), .stat_d_grants(stat_d_grants),
    .stat_f_stall(stat_f_stall), .stat_flushed(stat_flushed)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(int a);
    return (a == 5) ? 32'h2881000A : 32'hC0DE0000 + a * 32'h101;
  endfunction

  // Memory macro: RD_LAT-cycle read pipeline; unused slots carry junk so wrong timing shows.
  logic [31:0] pm [0:1023];
  logic [31:0] dl [1:4];
  logic loaded = 1'b0;
  always @(posedge clk1) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) pm[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_en && mem_we) pm[mem_addr] <= mem_wdata;
    dl[1] <= (mem_en && !mem_we) ? pm[mem_addr] : 32'hBADBAD00;
    for (int k = 2; k <= 4; k++) dl[k] <= dl[k-1];
  end
  assign mem_rdata = dl[RD_LAT];

  // Reference model: tracks only the decision edge of the current transaction and
  // derives every output from fixed offsets to it.
  logic [31:0] mm [0:1023];
  int n = 0, t_dec = -1000, free_edge = 0, starve = 0;
  bit own_f, is_rd, flsh;
  logic [31:0] rd_val, e_frd, e_drd, e_wd;
  logic [AW-1:0] e_addr;
  bit e_fg, e_dg, e_en, e_we, e_fv, e_dv, e_busy;

  task automatic model_step();
    bit fw;
    n++;
    e_fg = 0; e_dg = 0; e_en = 0; e_fv = 0; e_dv = 0;
    if (!rst_n) begin
      free_edge = n + 1; t_dec = -1000; own_f = 0; is_rd = 0; flsh = 0; starve = 0;
      e_frd = '0; e_drd = '0; e_busy = 0;
      return;
    end
    if (own_f && is_rd && n >= t_dec + 1 && n <= t_dec + RD_LAT + 1 && f_flush) flsh = 1;
    if (is_rd && n == t_dec + RD_LAT + 1) begin
      if (own_f) begin e_frd = rd_val; e_fv = !flsh; end
      else begin e_drd = rd_val; e_dv = 1; end
    end
    if (n >= free_edge) begin
      fw = f_req && (!d_req || starve == MAX_STARVE);
      if (!f_req || fw) starve = 0;
      else if (starve < MAX_STARVE) starve++;
      if (f_req || d_req) begin
        t_dec = n; own_f = fw; flsh = 0;
        is_rd = fw || !d_we;
        e_fg = fw; e_dg = !fw; e_en = 1; e_we = !fw && d_we;
        e_addr = fw ? f_addr : d_addr; e_wd = d_wdata;
        if (e_we) mm[e_addr] = d_wdata;
        rd_val = mm[e_addr];
        free_edge = is_rd ? n + RD_LAT + 3 : n + 2;
      end
    end
    e_busy = (n < free_edge - 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mm[i] = init_word(i);
    forever begin
      @(posedge clk1);
      model_step();
      @(negedge clk1);
      chk("f_gnt", f_gnt, e_fg);
      chk("d_gnt", d_gnt, e_dg);
      chk("mem_en", mem_en, e_en);
      chk("busy", busy, e_busy);
      chk("f_rvalid", f_rvalid, e_fv);
      chk("d_rvalid", d_rvalid, e_dv);
      chk("f_rdata", f_rdata, e_frd);
      chk("d_rdata", d_rdata, e_drd);
      if (e_en) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      end
    end
  end

  task automatic tick(int k);
    repeat (k) @(negedge clk1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 50) begin tick(1); b++; end
    if (b >= 50) chk("idle_timeout", busy, 32'd0);
    tick(1);
  endtask

  task automatic do_vec(input bit f, input bit d, input bit we, input int fa, input int da,
                        input logic [31:0] wd);
    int b = 0;
    f_req = f; f_addr = AW'(fa); d_req = d; d_we = we; d_addr = AW'(da); d_wdata = wd;
    while ((f_req || d_req) && b < 100) begin
      tick(1); b++;
      if (f_gnt) f_req = 0;
      if (d_gnt) begin d_req = 0; d_we = 0; end
    end
    if (b >= 100) chk("gnt_timeout", {30'd0, f_req, d_req}, 32'd0);
    f_req = 0; d_req = 0;
    wait_idle();
  endtask

  string ord;
  bit fv_seen;

  initial begin
    tick(2);
    chk("rst_busy", busy, 0); chk("rst_mem_en", mem_en, 0); chk("rst_f_rdata", f_rdata, 0);
    rst_n = 1;
    tick(1);

    // Single fetch of mem[5]
    f_req = 1; f_addr = 5;
    tick(1);
    chk("t1_f_gnt", f_gnt, 1); chk("t1_mem_en", mem_en, 1); chk("t1_mem_addr", mem_addr, 5);
    f_req = 0;
    tick(2); chk("t1_rvalid_early", f_rvalid, 0);
    tick(1); chk("t1_f_rvalid", f_rvalid, 1); chk("t1_f_rdata", f_rdata, 32'h2881000A);
    wait_idle();

    // Store then load back
    d_req = 1; d_we = 1; d_addr = 20; d_wdata = 32'h55;
    tick(1);
    chk("t2_d_gnt", d_gnt, 1); chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 20); chk("t2_mem_wdata", mem_wdata, 32'h55);
    d_req = 0; d_we = 0;
    tick(1); chk("t2_busy_low", busy, 0);
    tick(2);
    d_req = 1; d_addr = 20;
    tick(1); d_req = 0;
    tick(RD_LAT + 1); chk("t3_d_rvalid", d_rvalid, 1); chk("t3_d_rdata", d_rdata, 32'h55);
    wait_idle();

    // Starvation: both held
    ord = "";
    begin
      int g = 0, b = 0;
      f_req = 1; f_addr = 7; d_req = 1; d_we = 0; d_addr = 30;
      while (g < 8 && b < 200) begin
        tick(1); b++;
        if (f_gnt) begin ord = {ord, "F"}; g++; end
        if (d_gnt) begin ord = {ord, "D"}; g++; end
      end
      f_req = 0; d_req = 0;
    end
    checks++;
    if (ord != "DDDFDDDF") begin
      errors++;
      $display("FAIL grant_order: got %s expected DDDFDDDF", ord);
    end
    wait_idle();

    // Flush in RD_WAIT suppresses the response
    f_req = 1; f_addr = 9;
    tick(1); chk("t5_f_gnt", f_gnt, 1); f_req = 0;
    tick(1); f_flush = 1;
    tick(1); f_flush = 0;
    fv_seen = f_rvalid;
    repeat (6) begin tick(1); if (f_rvalid) fv_seen = 1; end
    chk("t5_flush_suppress", fv_seen, 0);
`ifdef ARB_STATS_EN
    chk("t5_stat_flushed", stat_flushed, 1);
`endif
    f_req = 1; f_addr = 10;
    tick(1); f_req = 0;
    tick(RD_LAT + 1); chk("t5_next_rvalid", f_rvalid, 1); chk("t5_next_rdata", f_rdata, 32'hC0DE0A0A);
    wait_idle();

    // Flush in IDLE and during a D load has no effect
    f_flush = 1; tick(1); f_flush = 0;
    d_req = 1; d_we = 0; d_addr = 40;
    tick(1); d_req = 0; f_flush = 1;
    tick(1); f_flush = 0;
    wait_idle();
    do_vec(1, 0, 0, 12, 0, 0);

    // Reset during RD_WAIT abandons the fetch
    f_req = 1; f_addr = 11;
    tick(1); f_req = 0;
    tick(1); rst_n = 0;
    tick(1);
    chk("t6_f_gnt", f_gnt, 0); chk("t6_mem_en", mem_en, 0); chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_we", mem_we, 0); chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_f_rdata", f_rdata, 0); chk("t6_d_rdata", d_rdata, 0); chk("t6_busy", busy, 0);
    rst_n = 1;
    fv_seen = 0;
    repeat (8) begin tick(1); if (f_rvalid) fv_seen = 1; end
    chk("t6_no_rvalid", fv_seen, 0);

    // Directed vectors
    do_vec(0, 1, 1, 0, 200, 32'hA5A50001);
    do_vec(1, 0, 0, 200, 0, 0);
    chk("v_fetch200", f_rdata, 32'hA5A50001);
    do_vec(1, 1, 0, 201, 200, 0);
    do_vec(0, 1, 1, 0, 1023, 32'hFFFFFFFF);
    do_vec(0, 1, 0, 0, 1023, 0);
    chk("v_load1023", d_rdata, 32'hFFFFFFFF);
    do_vec(0, 1, 0, 0, 0, 0);
    chk("v_load0", d_rdata, 32'hC0DE0000);
    do_vec(1, 1, 1, 0, 0, 32'h00000001);
    do_vec(1, 0, 0, 0, 0, 0);
    chk("v_fetch0", f_rdata, 32'h00000001);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
